// File: rtl/bool_mma_seq.sv
// rtl/bool_mma_seq.sv - sequential NxN boolean matrix multiply-accumulate
//
// Computes OUT = A*B + C one k-step per cycle over the boolean (OR) or
// GF(2) (XOR) semiring, with optional chaining of the previous result as C.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   operand-set handshake (A_flat, B_flat, C_flat, use_prev)
//   use_prev            1 = start from the last result instead of C_flat
//   A_flat/B_flat/C_flat  N*N-bit row-major matrices, element (r,c) at r*N+c
//   out_valid/out_ready result handshake
//   OUT_flat            N*N-bit result, held until the handshake completes
//   busy                high while computing or holding a result

module bool_mma_seq #(
  parameter int N    = 4,
  parameter int MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             use_prev,
  input  logic [N*N-1:0]   A_flat,
  input  logic [N*N-1:0]   B_flat,
  input  logic [N*N-1:0]   C_flat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N-1:0]   OUT_flat,
  output logic             busy
);

  localparam int KW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    a_rows [N];
  logic [N-1:0]    b_rows [N];
  logic [N*N-1:0]  acc;
  logic [N*N-1:0]  acc_next;
  // The result register doubles as the chaining source: it is written only
  // when an operation completes and cleared by reset, exactly like prev.
  logic [N*N-1:0]  result;
  logic [KW-1:0]   k;

  // One k-step: every element picks up A[r][k] & B[k][c].
  always_comb begin
    acc_next = acc;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (MODE == 1) begin
          acc_next[r*N+c] = acc[r*N+c] ^ (a_rows[r][k] & b_rows[k][c]);
        end else begin
          acc_next[r*N+c] = acc[r*N+c] | (a_rows[r][k] & b_rows[k][c]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      result <= '0;
      k      <= '0;
      for (int r = 0; r < N; r++) begin
        a_rows[r] <= '0;
        b_rows[r] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int r = 0; r < N; r++) begin
              a_rows[r] <= A_flat[r*N +: N];
              b_rows[r] <= B_flat[r*N +: N];
            end
            acc   <= use_prev ? result : C_flat;
            k     <= '0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc <= acc_next;
          if (k == KW'(N - 1)) begin
            result <= acc_next;
            k      <= '0;
            state  <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          // Returning to IDLE first keeps in_ready low during the handshake cycle.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign OUT_flat  = result;

endmodule

// File: tb/tb_bool_mma_seq.sv
// tb/tb_bool_mma_seq.sv - self-checking bench for bool_mma_seq (N=4, both modes)

module tb_bool_mma_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        use_prev;
  logic [15:0] a_in, b_in, c_in;
  logic        out_ready;

  logic        in_ready0, out_valid0, busy0;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] out0, out1;

  int tests = 0;
  int fails = 0;

  logic [15:0] prev0 = '0;
  logic [15:0] prev1 = '0;

  always #5 clk = ~clk;

  bool_mma_seq #(.N(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .use_prev(use_prev), .A_flat(a_in), .B_flat(b_in), .C_flat(c_in),
    .out_valid(out_valid0), .out_ready(out_ready), .OUT_flat(out0), .busy(busy0)
  );

  bool_mma_seq #(.N(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .use_prev(use_prev), .A_flat(a_in), .B_flat(b_in), .C_flat(c_in),
    .out_valid(out_valid1), .out_ready(out_ready), .OUT_flat(out1), .busy(busy1)
  );

  // Reference: count the ones in each dot product, then OR or XOR into C.
  function automatic logic [15:0] ref_mma(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input int mode);
    logic [15:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int cc = 0; cc < 4; cc++) begin
        int ones;
        ones = 0;
        for (int kk = 0; kk < 4; kk++) begin
          if (a[r*4+kk] && b[kk*4+cc]) ones++;
        end
        if (mode == 1) res[r*4+cc] = c[r*4+cc] ^ (ones % 2 == 1);
        else           res[r*4+cc] = c[r*4+cc] | (ones > 0);
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; holds out_ready low for 'hold' cycles in DONE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic up, input int hold,
                        output logic [15:0] r0, output logic [15:0] r1);
    logic [15:0] e0, e1, held;
    int cycles;
    e0 = ref_mma(a, b, up ? prev0 : c, 0);
    e1 = ref_mma(a, b, up ? prev1 : c, 1);
    check({tag, " in_ready before"}, {30'd0, in_ready1, in_ready0}, 32'h3);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    c_in      = c;
    use_prev  = up;
    out_ready = (hold == 0);
    tick();
    // Inputs must be ignored while computing.
    in_valid = 1'b0;
    a_in     = 16'($urandom);
    b_in     = 16'($urandom);
    c_in     = 16'($urandom);
    use_prev = 1'($urandom);
    check({tag, " busy after accept"}, {30'd0, busy1, busy0}, 32'h3);
    cycles = 1;
    while (!out_valid0 && cycles < 20) begin
      a_in = 16'($urandom);
      tick();
      if (!out_valid0) cycles++;
    end
    check({tag, " latency"}, cycles, 4);
    check({tag, " out_valid both"}, {30'd0, out_valid1, out_valid0}, 32'h3);
    check({tag, " out mode0"}, out0, e0);
    check({tag, " out mode1"}, out1, e1);
    prev0 = e0;
    prev1 = e1;
    r0 = out0;
    r1 = out1;
    held = out0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a_in     = 16'($urandom);
      tick();
      check({tag, " hold out"}, out0, held);
      check({tag, " hold flags"}, {29'd0, out_valid0, in_ready0, busy0}, 32'h5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({tag, " handshake flags"}, {29'd0, out_valid0, in_ready0, busy0}, 32'h2);
    check({tag, " out after handshake"}, out0, held);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r0, r1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    use_prev  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset flags0", {29'd0, out_valid0, in_ready0, busy0}, 32'h2);
    check("reset flags1", {29'd0, out_valid1, in_ready1, busy1}, 32'h2);
    check("reset out", {out1, out0}, 32'h0);
    rst_n = 1'b1;
    tick();

    // use_prev straight after reset behaves like C=0.
    run_op("prev_after_reset", 16'h8421, 16'h1234, 16'hFFFF, 1'b1, 0, r0, r1);
    check("prev_after_reset const", r0, 16'h1234);

    run_op("identity", 16'h8421, 16'h1234, 16'h0000, 1'b0, 0, r0, r1);
    check("identity const", {r1, r0}, 32'h1234_1234);

    run_op("col0", 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 0, r0, r1);
    check("col0 const", r0, 16'h1111);
    run_op("col0_c", 16'hFFFF, 16'h0001, 16'h8000, 1'b0, 0, r0, r1);
    check("col0_c const", r0, 16'h9111);

    run_op("ones", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 0, r0, r1);
    check("ones const", {r1, r0}, 32'h0000_FFFF);
    run_op("ones_c1", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 0, r0, r1);
    check("ones_c1 mode1 const", r1, 16'h0001);

    run_op("chain1", 16'h8421, 16'h00F0, 16'h0000, 1'b0, 0, r0, r1);
    check("chain1 const", r0, 16'h00F0);
    run_op("chain2", 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 0, r0, r1);
    check("chain2 const", r0, 16'h00F0);
    run_op("chain3", 16'h8421, 16'h0F00, 16'h0000, 1'b1, 0, r0, r1);
    check("chain3 const", {r1, r0}, 32'h0FF0_0FF0);

    run_op("backpressure", 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 5, r0, r1);
    run_op("after_bp_chain", 16'h8421, 16'h0000, 16'h0000, 1'b1, 0, r0, r1);

    for (int i = 0; i < 16; i++) begin
      run_op("random", 16'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom), int'($urandom_range(0, 2)), r0, r1);
    end

    // Reset on the second compute cycle discards the operation.
    in_valid = 1'b1;
    a_in     = 16'hFFFF;
    b_in     = 16'hFFFF;
    c_in     = 16'h00FF;
    use_prev = 1'b0;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset flags0", {29'd0, out_valid0, in_ready0, busy0}, 32'h2);
    check("midreset flags1", {29'd0, out_valid1, in_ready1, busy1}, 32'h2);
    check("midreset out", {out1, out0}, 32'h0);
    prev0 = '0;
    prev1 = '0;
    run_op("post_reset_prev", 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 0, r0, r1);
    check("post_reset_prev const", {r1, r0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
